// File: rtl/n_bit_seq_divider.sv
// n_bit_seq_divider: multi-cycle signed/unsigned restoring divider.
//
// Produces one quotient bit per clock after a valid/ready accept. Operands
// are reduced to magnitudes at accept, divided unsigned, then sign-fixed.
// The quotient truncates toward zero and the remainder takes the dividend's
// sign. Division by zero and signed MIN / -1 are flagged.
//
// Build option:
//   SEQ_DIV_EARLY_OUT_EN - when defined, an operation with b != 0 and
//                          |a| < |b| skips the shift loop and finishes at
//                          accept (quotient = 0, remainder = a).
//
// Timing (accept at edge k):
//   b == 0 or early-out : out_valid rises at edge k+1
//   otherwise           : out_valid rises at edge k+N+2

module n_bit_seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         signed_mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int            CW      = $clog2(N);
    localparam logic [N-1:0]  MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;        // CALC steps left after the current one
    logic          sign_a;     // dividend negative (signed mode only)
    logic          sign_b;     // divisor negative (signed mode only)
    logic          ovf_pend;   // MIN / -1 detected at accept
    logic [N-1:0]  dvd_q;      // dividend bits shift out of the top while
                               // quotient bits shift in at the bottom
    logic [N-1:0]  dvs_mag;    // |b|
    logic [N-1:0]  rem_r;      // partial remainder; always < |b| so N bits hold it

    // Accept-time operand decode and the per-cycle restoring step.
    logic          in_sign_a;
    logic          in_sign_b;
    logic [N-1:0]  in_mag_a;
    logic [N-1:0]  in_mag_b;
    logic          in_ovf;
    logic [N:0]    rem_shift;
    logic [N:0]    rem_diff;
    logic          q_bit;

    // Combinational decode of the incoming operands and the trial subtraction.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        in_sign_a = signed_mode & a[N-1];
        in_sign_b = signed_mode & b[N-1];
        // Negating MIN yields MIN again, which read as unsigned is 2^(N-1):
        // exactly the magnitude we need, so no extra bit is required.
        in_mag_a  = in_sign_a ? -a : a;
        in_mag_b  = in_sign_b ? -b : b;
        in_ovf    = signed_mode && (a == MIN_VAL) && (b == '1);

        // rem_r < |b|, so the shifted value is < 2*|b| and fits in N+1 bits;
        // a non-negative difference is then < |b| and its top bit is 0.
        rem_shift = {rem_r, dvd_q[N-1]};
        rem_diff  = rem_shift - {1'b0, dvs_mag};
        q_bit     = ~rem_diff[N];
    end

    // Control FSM, datapath registers and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            cnt         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            ovf_pend    <= 1'b0;
            dvd_q       <= '0;
            dvs_mag     <= '0;
            rem_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_a   <= in_sign_a;
                        sign_b   <= in_sign_b;
                        ovf_pend <= in_ovf;
                        dvd_q    <= in_mag_a;
                        dvs_mag  <= in_mag_b;
                        rem_r    <= '0;
                        cnt      <= CW'(N - 1);
                        if (b == '0) begin
                            // Divide by zero: report all-ones / dividend.
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            state       <= DONE;
                        end
`ifdef SEQ_DIV_EARLY_OUT_EN
                        else if (in_mag_a < in_mag_b) begin
                            // Dividend smaller than divisor: quotient is 0
                            // and the remainder is the dividend unchanged.
                            quotient    <= '0;
                            remainder   <= a;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            state       <= DONE;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    // One restoring step: keep the difference if it did not
                    // go negative, otherwise keep the shifted remainder.
                    dvd_q <= {dvd_q[N-2:0], q_bit};
                    if (q_bit) begin
                        rem_r <= rem_diff[N-1:0];
                    end else begin
                        rem_r <= rem_shift[N-1:0];
                    end
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                FIX: begin
                    // MIN / -1 needs no special case: the magnitude quotient
                    // 2^(N-1) negates back to MIN and the remainder is 0.
                    quotient    <= (sign_a ^ sign_b) ? -dvd_q : dvd_q;
                    remainder   <= sign_a ? -rem_r : rem_r;
                    div_by_zero <= 1'b0;
                    overflow    <= ovf_pend;
                    state       <= DONE;
                end

                DONE: begin
                    // Results were written on entry; valid follows one cycle
                    // later and then holds until the consumer takes it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_bit_seq_divider.sv
// Self-checking bench for n_bit_seq_divider (N = 8).
// Expected results come from native integer division and are queued when an
// operation is driven, then popped and compared when out_valid appears.

module tb_n_bit_seq_divider;

    localparam int N        = 8;
    localparam int FULL_LAT = N + 2;
    localparam int MAX_WAIT = 50;

    logic         clk         = 1'b0;
    logic         rst_n       = 1'b0;
    logic         in_valid    = 1'b0;
    logic         signed_mode = 1'b0;
    logic [N-1:0] a           = '0;
    logic [N-1:0] b           = '0;
    logic         out_ready   = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    n_bit_seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result from native integer division (truncates toward zero).
    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                   input logic sm);
        exp_t e;
        int   sa_i;
        int   sb_i;
        int   qi;
        int   ri;
        int   ma;
        int   mb;
        sa_i = sm ? int'($signed(av)) : int'(av);
        sb_i = sm ? int'($signed(bv)) : int'(bv);
        if (bv == '0) begin
            e.q   = '1;
            e.r   = av;
            e.dz  = 1'b1;
            e.ov  = 1'b0;
            e.lat = 1;
            return e;
        end
        qi    = sa_i / sb_i;
        ri    = sa_i % sb_i;
        e.q   = qi[N-1:0];
        e.r   = ri[N-1:0];
        e.dz  = 1'b0;
        e.ov  = sm && (av == 8'h80) && (bv == 8'hFF);
        ma    = (sa_i < 0) ? -sa_i : sa_i;
        mb    = (sb_i < 0) ? -sb_i : sb_i;
        e.lat = FULL_LAT;
`ifdef SEQ_DIV_EARLY_OUT_EN
        if (ma < mb) e.lat = 1;
`else
        if (ma < 0 || mb < 0) e.lat = 0;  // magnitudes are never negative
`endif
        return e;
    endfunction

    // Drive one operation, then wait (bounded) for its result and compare.
    // hold > 0 keeps out_ready low for that many cycles after out_valid.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic sm, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a           = av;
        b           = bv;
        signed_mode = sm;
        in_valid    = 1'b1;
        out_ready   = (hold == 0);
        sb.push_back(model(av, bv, sm));
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        a           = N'($urandom);
        b           = N'($urandom);
        signed_mode = ~sm;
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        do begin
            if (lat > 0 || !out_valid) begin
                @(posedge clk);
                #1;
            end
            lat++;
        end while (!out_valid && lat < MAX_WAIT);
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
        check("overflow", overflow, e.ov);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_quotient", quotient, e.q);
            check("bp_remainder", remainder, e.r);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd100, 8'd7, 1'b0, 0);
        run_op(8'hF9, 8'h02, 1'b1, 0);
        run_op(8'h07, 8'hFE, 1'b1, 0);
        run_op(8'h80, 8'hFF, 1'b1, 0);
        run_op(8'h80, 8'hFF, 1'b0, 0);
        run_op(8'd5, 8'd0, 1'b0, 0);
        run_op(8'd5, 8'd0, 1'b1, 0);
        run_op(8'd3, 8'd10, 1'b0, 0);
        run_op(8'h9C, 8'd7, 1'b1, 5);

        // Abort an operation mid-CALC with reset; nothing must come out.
        @(negedge clk);
        a           = 8'd200;
        b           = 8'd9;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        check("abort_no_valid", out_valid, 0);

        run_op(8'd100, 8'd7, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
